// File: rtl/packet_sink_buffer_if.sv
// Channel/packet bundle between a NoC packet source/consumer and packet_sink_buffer.
// The slave side is the sink buffer; the master side drives flits and consumes packets.
interface packet_sink_buffer_if #(
  parameter int CHANNEL_WIDTH    = 32,
  parameter int FLITS_PER_PACKET = 5,
  parameter int SERIAL_WIDTH     = 18,
  parameter int TS_WIDTH         = 32
);
  logic [CHANNEL_WIDTH-1:0]                  channel_in;
  logic                                      credit_out;
  logic                                      pkt_valid;
  logic                                      pkt_ready;
  logic [CHANNEL_WIDTH*FLITS_PER_PACKET-1:0] pkt_data;
  logic [SERIAL_WIDTH-1:0]                   pkt_serial;
  logic [TS_WIDTH-1:0]                       pkt_timestamp;

  modport master (
    output channel_in, pkt_ready,
    input  credit_out, pkt_valid, pkt_data, pkt_serial, pkt_timestamp
  );

  modport slave (
    input  channel_in, pkt_ready,
    output credit_out, pkt_valid, pkt_data, pkt_serial, pkt_timestamp
  );
endinterface

// File: rtl/packet_sink_buffer.sv
// Frames fixed-length packets off an idle-zero flit channel, stamps them at tail
// arrival and queues whole packets in a small FIFO, returning one credit per pop.
module packet_sink_buffer #(
  parameter int CHANNEL_WIDTH    = 32,
  parameter int FLITS_PER_PACKET = 5,
  parameter int SERIAL_WIDTH     = 18,
  parameter int FIFO_DEPTH       = 4,
  parameter int TS_WIDTH         = 32,
  parameter int COUNT_WIDTH      = 16,
  parameter bit DRAIN_MODE       = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  packet_sink_buffer_if.slave    bus,
  output logic [COUNT_WIDTH-1:0] packet_count,
  output logic                   overflow_err
);

  localparam int PKT_W = CHANNEL_WIDTH * FLITS_PER_PACKET;
  localparam int CNT_W = $clog2(FLITS_PER_PACKET);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, RECV} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           flit_cnt_q, flit_cnt_d;
  logic [PKT_W-CHANNEL_WIDTH-1:0] asm_q, asm_d;
  logic [TS_WIDTH-1:0]        ts_q;
  logic [PTR_W:0]             wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0]     count_q;
  logic                       credit_q;
  logic                       overflow_q;

  logic [PKT_W-1:0]           push_data;
  logic                       push_req;
  logic                       fifo_empty, fifo_full;
  logic                       pop, accept;

  logic [PKT_W-1:0]           data_mem   [FIFO_DEPTH];
  logic [SERIAL_WIDTH-1:0]    serial_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]        ts_mem     [FIFO_DEPTH];

  // Shift register: after the tail is appended the header sits in the MSBs.
  assign push_data = {asm_q, bus.channel_in};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    asm_d      = asm_q;
    push_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.channel_in != '0) begin
          asm_d      = push_data[PKT_W-CHANNEL_WIDTH-1:0];
          flit_cnt_d = CNT_W'(1);
          state_d    = RECV;
        end
      end
      RECV: begin
        asm_d = push_data[PKT_W-CHANNEL_WIDTH-1:0];
        if (flit_cnt_q == CNT_W'(FLITS_PER_PACKET - 1)) begin
          push_req   = 1'b1;
          flit_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          flit_cnt_d = flit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && (bus.pkt_ready || DRAIN_MODE);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign accept     = push_req && (!fifo_full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      flit_cnt_q <= '0;
      asm_q      <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      asm_q      <= asm_d;
      ts_q       <= ts_q + TS_WIDTH'(1);
      credit_q   <= pop;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
        if (count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: packet storage is not reset; outputs are gated by pkt_valid so stale slots never show.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr_q[PTR_W-1:0]]   <= push_data;
      serial_mem[wr_ptr_q[PTR_W-1:0]] <= push_data[PKT_W-CHANNEL_WIDTH +: SERIAL_WIDTH];
      ts_mem[wr_ptr_q[PTR_W-1:0]]     <= ts_q;
    end
  end

  assign bus.pkt_valid     = !fifo_empty;
  assign bus.credit_out    = credit_q;
  assign bus.pkt_data      = fifo_empty ? '0 : data_mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.pkt_serial    = fifo_empty ? '0 : serial_mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.pkt_timestamp = fifo_empty ? '0 : ts_mem[rd_ptr_q[PTR_W-1:0]];
  assign packet_count      = count_q;
  assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_packet_sink_buffer.sv
// Directed bench for packet_sink_buffer: a vector table for framing/timestamps
// plus hand-written sequences for backpressure, overflow, drain mode and reset.
module tb_packet_sink_buffer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  packet_sink_buffer_if a_if ();
  packet_sink_buffer_if b_if ();
  logic [15:0] a_count, b_count;
  logic        a_ovf, b_ovf;

  packet_sink_buffer dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave),
    .packet_count(a_count), .overflow_err(a_ovf)
  );

  packet_sink_buffer #(.DRAIN_MODE(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave),
    .packet_count(b_count), .overflow_err(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0]  ch;
    logic         rdy;
    logic         ev;
    logic [17:0]  es;
    logic [31:0]  ets;
    logic         ec;
    logic [15:0]  ecnt;
    logic [159:0] ed;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flit(input logic [17:0] s, input int k);
    if (k == 0) return {14'b0, s};
    return 32'hB000_0000 | {6'b0, s, 8'(k)};
  endfunction

  function automatic logic [159:0] pkt_of(input logic [17:0] s);
    logic [159:0] d;
    for (int k = 0; k < 5; k++) d[(5-k)*32-1 -: 32] = flit(s, k);
    return d;
  endfunction

  function automatic vec_t mk(input logic [31:0] ch, input logic rdy, input logic ev,
                              input logic [17:0] es, input logic [31:0] ets, input logic ec,
                              input logic [15:0] ecnt, input logic [159:0] ed);
    vec_t v;
    v.ch = ch; v.rdy = rdy; v.ev = ev; v.es = es; v.ets = ets;
    v.ec = ec; v.ecnt = ecnt; v.ed = ed;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    a_if.channel_in = '0; a_if.pkt_ready = 1'b0;
    b_if.channel_in = '0; b_if.pkt_ready = 1'b0;
    tick();
    tick();
    check("rst_valid",  256'(a_if.pkt_valid), 256'(1'b0));
    check("rst_credit", 256'(a_if.credit_out), 256'(1'b0));
    check("rst_count",  256'(a_count), 256'(16'd0));
    check("rst_ovf",    256'(a_ovf), 256'(1'b0));
    check("rst_data",   256'(a_if.pkt_data), 256'(160'd0));
    check("rst_serial", 256'(a_if.pkt_serial), 256'(18'd0));
    check("rst_ts",     256'(a_if.pkt_timestamp), 256'(32'd0));
    check("rst_b_valid", 256'(b_if.pkt_valid), 256'(1'b0));
    reset_n = 1'b1;
  endtask

  // Drives one 5-flit packet on the A channel; pkt_ready is set to tail_rdy only for the tail edge.
  task automatic send_a(input logic [17:0] s, input logic tail_rdy);
    logic saved_rdy;
    saved_rdy = a_if.pkt_ready;
    for (int k = 0; k < 5; k++) begin
      a_if.channel_in = flit(s, k);
      if (k == 4) a_if.pkt_ready = tail_rdy;
      tick();
    end
    a_if.channel_in = '0;
    a_if.pkt_ready  = saved_rdy;
  endtask

  initial begin
    a_if.channel_in = '0; a_if.pkt_ready = 1'b0;
    b_if.channel_in = '0; b_if.pkt_ready = 1'b0;

    // Row i is applied before edge i after reset release; edge i samples timestamp i.
    tbl[0] = mk(32'h0003_0025, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(32'h1111_1111, 1, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(32'h2222_2222, 1, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(32'h0000_0000, 1, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(32'h4444_4444, 1, 1, 18'h30025, 4, 0, 1,
                {32'h0003_0025, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h4444_4444});
    tbl[5] = mk(32'h0, 1, 0, 0, 0, 1, 1, 0);
    tbl[6] = mk(32'h0, 1, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(flit(1, 0), 1, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(flit(1, 1), 1, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(flit(1, 2), 1, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(flit(1, 3), 1, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(flit(1, 4), 1, 1, 1, 11, 0, 2, pkt_of(1));
    tbl[12] = mk(flit(2, 0), 1, 0, 0, 0, 1, 2, 0);
    tbl[13] = mk(flit(2, 1), 1, 0, 0, 0, 0, 2, 0);
    tbl[14] = mk(flit(2, 2), 1, 0, 0, 0, 0, 2, 0);
    tbl[15] = mk(flit(2, 3), 1, 0, 0, 0, 0, 2, 0);
    tbl[16] = mk(flit(2, 4), 1, 1, 2, 16, 0, 3, pkt_of(2));
    tbl[17] = mk(flit(3, 0), 1, 0, 0, 0, 1, 3, 0);
    tbl[18] = mk(flit(3, 1), 1, 0, 0, 0, 0, 3, 0);
    tbl[19] = mk(flit(3, 2), 1, 0, 0, 0, 0, 3, 0);
    tbl[20] = mk(flit(3, 3), 1, 0, 0, 0, 0, 3, 0);
    tbl[21] = mk(flit(3, 4), 1, 1, 3, 21, 0, 4, pkt_of(3));
    tbl[22] = mk(32'h0, 1, 0, 0, 0, 1, 4, 0);
    tbl[23] = mk(32'h0, 1, 0, 0, 0, 0, 4, 0);

    // Single packet and back-to-back packets.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      a_if.channel_in = tbl[i].ch;
      a_if.pkt_ready  = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i),  256'(a_if.pkt_valid),  256'(tbl[i].ev));
      check($sformatf("tbl%0d_credit", i), 256'(a_if.credit_out), 256'(tbl[i].ec));
      check($sformatf("tbl%0d_count", i),  256'(a_count),         256'(tbl[i].ecnt));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_serial", i), 256'(a_if.pkt_serial),    256'(tbl[i].es));
        check($sformatf("tbl%0d_ts", i),     256'(a_if.pkt_timestamp), 256'(tbl[i].ets));
        check($sformatf("tbl%0d_data", i),   256'(a_if.pkt_data),      256'(tbl[i].ed));
      end
    end
    a_if.channel_in = '0;

    // Backpressure: four packets fill the FIFO, the fifth is dropped.
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      send_a(18'(s), 1'b0);
      check($sformatf("bp%0d_count", s),  256'(a_count),         256'(16'(s)));
      check($sformatf("bp%0d_head", s),   256'(a_if.pkt_serial), 256'(18'd1));
      check($sformatf("bp%0d_credit", s), 256'(a_if.credit_out), 256'(1'b0));
      check($sformatf("bp%0d_ovf", s),    256'(a_ovf),           256'(1'b0));
    end
    send_a(18'd5, 1'b0);
    check("ovf_set",    256'(a_ovf),           256'(1'b1));
    check("ovf_count",  256'(a_count),         256'(16'd4));
    check("ovf_credit", 256'(a_if.credit_out), 256'(1'b0));
    tick();
    check("ovf_sticky", 256'(a_ovf), 256'(1'b1));
    for (int s = 1; s <= 4; s++) begin
      check($sformatf("drain%0d_serial", s), 256'(a_if.pkt_serial), 256'(18'(s)));
      a_if.pkt_ready = 1'b1;
      tick();
      check($sformatf("drain%0d_credit", s), 256'(a_if.credit_out), 256'(1'b1));
    end
    check("drain_empty", 256'(a_if.pkt_valid), 256'(1'b0));
    a_if.pkt_ready = 1'b0;
    tick();
    check("drain_credit_off", 256'(a_if.credit_out), 256'(1'b0));

    // Full FIFO with a pop on the same edge as the tail.
    do_reset();
    for (int s = 1; s <= 4; s++) send_a(18'(s), 1'b0);
    send_a(18'd5, 1'b1);
    check("fullpop_ovf",    256'(a_ovf),           256'(1'b0));
    check("fullpop_count",  256'(a_count),         256'(16'd5));
    check("fullpop_head",   256'(a_if.pkt_serial), 256'(18'd2));
    check("fullpop_credit", 256'(a_if.credit_out), 256'(1'b1));
    for (int s = 2; s <= 5; s++) begin
      check($sformatf("fullpop_valid%0d", s),  256'(a_if.pkt_valid),  256'(1'b1));
      check($sformatf("fullpop_serial%0d", s), 256'(a_if.pkt_serial), 256'(18'(s)));
      a_if.pkt_ready = 1'b1;
      tick();
    end
    check("fullpop_empty", 256'(a_if.pkt_valid), 256'(1'b0));
    a_if.pkt_ready = 1'b0;

    // Drain mode ignores pkt_ready and pops each packet the edge after its tail.
    for (int p = 1; p <= 2; p++) begin
      for (int k = 0; k < 5; k++) begin
        b_if.channel_in = flit(18'(p), k);
        tick();
        if (k == 4) begin
          check($sformatf("drn%0d_valid", p),  256'(b_if.pkt_valid),  256'(1'b1));
          check($sformatf("drn%0d_serial", p), 256'(b_if.pkt_serial), 256'(18'(p)));
          check($sformatf("drn%0d_credit", p), 256'(b_if.credit_out), 256'(1'b0));
        end
        if (k == 0 && p == 2) begin
          check("drn1_popped", 256'(b_if.pkt_valid),  256'(1'b0));
          check("drn1_credit", 256'(b_if.credit_out), 256'(1'b1));
        end
      end
    end
    b_if.channel_in = '0;
    tick();
    check("drn2_popped", 256'(b_if.pkt_valid),  256'(1'b0));
    check("drn2_credit", 256'(b_if.credit_out), 256'(1'b1));
    tick();
    check("drn_credit_off", 256'(b_if.credit_out), 256'(1'b0));
    check("drn_count",      256'(b_count),         256'(16'd2));

    // Reset in the middle of a packet, then a clean packet afterwards.
    for (int k = 0; k < 3; k++) begin
      a_if.channel_in = flit(18'd9, k);
      tick();
    end
    reset_n = 1'b0;
    a_if.channel_in = '0;
    #1;
    check("midrst_valid", 256'(a_if.pkt_valid),  256'(1'b0));
    check("midrst_count", 256'(a_count),         256'(16'd0));
    check("midrst_ovf",   256'(a_ovf),           256'(1'b0));
    check("midrst_data",  256'(a_if.pkt_data),   256'(160'd0));
    tick();
    reset_n = 1'b1;
    send_a(18'd7, 1'b0);
    check("postrst_valid",  256'(a_if.pkt_valid),     256'(1'b1));
    check("postrst_serial", 256'(a_if.pkt_serial),    256'(18'd7));
    check("postrst_data",   256'(a_if.pkt_data),      256'(pkt_of(18'd7)));
    check("postrst_ts",     256'(a_if.pkt_timestamp), 256'(32'd4));
    check("postrst_count",  256'(a_count),            256'(16'd1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
